// File: rtl/rv_plic_target_claim_if.sv
// Claim/complete channel between a hart's claim/complete CSR and the PLIC
// per-target arbiter.
//
// Signals:
//   claim_req_i    single-cycle claim read strobe (hart -> PLIC)
//   claim_valid_o  single-cycle claim response strobe (PLIC -> hart)
//   claim_id_o     claimed ID, 0 = nothing claimed (PLIC -> hart)
//   complete_req_i single-cycle completion write strobe (hart -> PLIC)
//   complete_id_i  ID being completed (hart -> PLIC)
//
// Handshake: both requests are fire-and-forget strobes; the PLIC always
// accepts them. A claim_req_i at cycle t is answered by a one-cycle
// claim_valid_o pulse at t+1; claim_id_o then holds until the next claim.
// Completions take effect at the next edge and produce no response.
//
// Modports: master = hart / CSR side, slave = PLIC arbiter side.
interface rv_plic_target_claim_if #(
    parameter int SRCW = 6
);
    logic            claim_req_i;
    logic            claim_valid_o;
    logic [SRCW-1:0] claim_id_o;
    logic            complete_req_i;
    logic [SRCW-1:0] complete_id_i;

    modport master (
        output claim_req_i,
        output complete_req_i,
        output complete_id_i,
        input  claim_valid_o,
        input  claim_id_o
    );

    modport slave (
        input  claim_req_i,
        input  complete_req_i,
        input  complete_id_i,
        output claim_valid_o,
        output claim_id_o
    );
endinterface

// File: rtl/rv_plic_target_claim.sv
// Per-target PLIC arbiter with an optionally pipelined max-priority binary
// tree and an integrated claim/complete gateway. Claimed sources are masked
// out of arbitration until the hart completes them.
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   ip, ie         per-source pending and enable bits
//   prio           per-source priority
//   threshold      target threshold (strict: prio must exceed it)
//   cc             claim/complete channel (slave side)
//   irq_o          external interrupt request to the hart
//   irq_id_o       current winning ID, 0 if none
//   claimed_o      in-service mask
module rv_plic_target_claim #(
    parameter int N_SOURCE   = 32,
    parameter int MAX_PRIO   = 7,
    parameter int PIPE_EVERY = 2,
    parameter int SRCW       = $clog2(N_SOURCE + 1),
    parameter int PRIOW      = $clog2(MAX_PRIO + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [N_SOURCE-1:0]            ip,
    input  logic [N_SOURCE-1:0]            ie,
    input  logic [N_SOURCE-1:0][PRIOW-1:0] prio,
    input  logic [PRIOW-1:0]               threshold,
    rv_plic_target_claim_if.slave          cc,
    output logic                           irq_o,
    output logic [SRCW-1:0]                irq_id_o,
    output logic [N_SOURCE-1:0]            claimed_o
);
    localparam int N_LEVELS = $clog2(N_SOURCE);
    localparam int NLEAF    = 2 ** N_LEVELS;
    // Tree priority is one bit wider than strictly needed for MAX_PRIO.
    localparam int PW       = $clog2(MAX_PRIO + 2);
    // Guarded divisor so the expressions below stay legal when PIPE_EVERY == 0.
    localparam int PE_SAFE  = (PIPE_EVERY == 0) ? 1 : PIPE_EVERY;
    localparam int NPIPE    = (PIPE_EVERY == 0) ? 0 : (N_LEVELS - 1) / PE_SAFE;
    localparam int SETW     = $clog2(NPIPE + 2);

    logic [N_SOURCE-1:0] claimed_q, claimed_d;
    logic                irq_q, irq_d;
    logic [SRCW-1:0]     irq_id_q, irq_id_d;
    logic                claim_valid_q, claim_valid_d;
    logic [SRCW-1:0]     claim_id_q, claim_id_d;
    logic [SETW-1:0]     settle_q, settle_d;
    logic [SRCW-1:0]     claim_grant;
    logic                do_set;

    // Heap-ordered tree: node 1 is the root, node n has children 2n and
    // 2n+1, leaves occupy NLEAF..2*NLEAF-1. Each entry is the (possibly
    // registered) output of that node.
    logic            node_v  [1:2*NLEAF-1];
    logic [SRCW-1:0] node_id [1:2*NLEAF-1];
    logic [PW-1:0]   node_p  [1:2*NLEAF-1];

    for (genvar i = 0; i < NLEAF; i++) begin : g_leaf
        if (i < N_SOURCE) begin : g_used
            assign node_v[NLEAF+i]  = ip[i] & ie[i] & ~claimed_q[i];
            assign node_id[NLEAF+i] = SRCW'(i + 1);
            assign node_p[NLEAF+i]  = PW'(prio[i]);
        end else begin : g_unused
            assign node_v[NLEAF+i]  = 1'b0;
            assign node_id[NLEAF+i] = '0;
            assign node_p[NLEAF+i]  = '0;
        end
    end

    for (genvar n = 1; n < NLEAF; n++) begin : g_node
        // Level of node n, root = 0, leaves = N_LEVELS.
        localparam int LVL = $clog2(n + 1) - 1;
        localparam bit PIPE = (PIPE_EVERY > 0) && (LVL > 0) &&
                              (((N_LEVELS - LVL) % PE_SAFE) == 0);

        logic            sel;
        logic            v_d;
        logic [SRCW-1:0] id_d;
        logic [PW-1:0]   p_d;

        // Upper child wins only with strictly higher priority, so ties
        // resolve to the lower ID.
        always_comb begin
            sel  = node_v[2*n+1] & (~node_v[2*n] | (node_p[2*n+1] > node_p[2*n]));
            v_d  = node_v[2*n] | node_v[2*n+1];
            id_d = sel ? node_id[2*n+1] : node_id[2*n];
            p_d  = sel ? node_p[2*n+1]  : node_p[2*n];
        end

        if (PIPE) begin : g_pipe
            logic            v_q;
            logic [SRCW-1:0] id_q;
            logic [PW-1:0]   p_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    v_q  <= 1'b0;
                    id_q <= '0;
                    p_q  <= '0;
                end else begin
                    v_q  <= v_d;
                    id_q <= id_d;
                    p_q  <= p_d;
                end
            end

            assign node_v[n]  = v_q;
            assign node_id[n] = id_q;
            assign node_p[n]  = p_q;
        end else begin : g_comb
            assign node_v[n]  = v_d;
            assign node_id[n] = id_d;
            assign node_p[n]  = p_d;
        end
    end

    always_comb begin
        irq_d    = node_v[1] & (node_p[1] > PW'(threshold));
        irq_id_d = node_v[1] ? node_id[1] : '0;

        claim_grant   = ((settle_q == '0) && irq_q) ? irq_id_q : '0;
        do_set        = cc.claim_req_i && (claim_grant != '0);
        claim_valid_d = cc.claim_req_i;
        claim_id_d    = cc.claim_req_i ? claim_grant : claim_id_q;

        // After a successful claim the tree still holds the claimed source
        // for NPIPE+1 cycles; the settle counter blanks irq until it drains.
        if (do_set) begin
            settle_d = SETW'(NPIPE + 1);
        end else if (settle_q != '0) begin
            settle_d = settle_q - SETW'(1);
        end else begin
            settle_d = settle_q;
        end

        // Clear first, then set, so a same-bit claim and complete leaves
        // the bit set. Non-matching IDs (0, out of range) touch nothing.
        claimed_d = claimed_q;
        for (int i = 0; i < N_SOURCE; i++) begin
            if (cc.complete_req_i && (cc.complete_id_i == SRCW'(i + 1))) begin
                claimed_d[i] = 1'b0;
            end
            if (do_set && (claim_grant == SRCW'(i + 1))) begin
                claimed_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            claimed_q     <= '0;
            irq_q         <= 1'b0;
            irq_id_q      <= '0;
            claim_valid_q <= 1'b0;
            claim_id_q    <= '0;
            settle_q      <= '0;
        end else begin
            claimed_q     <= claimed_d;
            irq_q         <= irq_d;
            irq_id_q      <= irq_id_d;
            claim_valid_q <= claim_valid_d;
            claim_id_q    <= claim_id_d;
            settle_q      <= settle_d;
        end
    end

    assign irq_o            = irq_q & (settle_q == '0);
    assign irq_id_o         = (settle_q == '0) ? irq_id_q : '0;
    assign claimed_o        = claimed_q;
    assign cc.claim_valid_o = claim_valid_q;
    assign cc.claim_id_o    = claim_id_q;
endmodule

// File: tb/tb_rv_plic_target_claim.sv
// Testbench for rv_plic_target_claim (N_SOURCE=32, MAX_PRIO=7, PIPE_EVERY=2).
// Claim responses are scoreboarded: the expected ID is queued when the
// claim strobe is driven and checked when claim_valid_o pulses.
module tb_rv_plic_target_claim;
    localparam int N     = 32;
    localparam int SRCW  = 6;
    localparam int PRIOW = 3;

    logic                     clk_i;
    logic                     rst_ni;
    logic [N-1:0]             ip;
    logic [N-1:0]             ie;
    logic [N-1:0][PRIOW-1:0]  prio;
    logic [PRIOW-1:0]         threshold;
    logic                     irq_o;
    logic [SRCW-1:0]          irq_id_o;
    logic [N-1:0]             claimed_o;

    rv_plic_target_claim_if #(.SRCW(SRCW)) cc_if ();

    rv_plic_target_claim #(
        .N_SOURCE   (N),
        .MAX_PRIO   (7),
        .PIPE_EVERY (2)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .ip        (ip),
        .ie        (ie),
        .prio      (prio),
        .threshold (threshold),
        .cc        (cc_if),
        .irq_o     (irq_o),
        .irq_id_o  (irq_id_o),
        .claimed_o (claimed_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [SRCW-1:0] exp_q[$];

    // ---------------- clock ----------------
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Claim response monitor: pops the scoreboard on each response pulse.
    always @(negedge clk_i) begin
        if (rst_ni && cc_if.claim_valid_o) begin
            if (exp_q.size() == 0) begin
                check("claim_unexpected", 32'(cc_if.claim_valid_o), 32'd0);
            end else begin
                check("claim_id", 32'(cc_if.claim_id_o), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic claim(input logic [SRCW-1:0] exp_id);
        cc_if.claim_req_i = 1'b1;
        exp_q.push_back(exp_id);
        tick();
        cc_if.claim_req_i = 1'b0;
    endtask

    task automatic complete(input logic [SRCW-1:0] id);
        cc_if.complete_req_i = 1'b1;
        cc_if.complete_id_i  = id;
        tick();
        cc_if.complete_req_i = 1'b0;
        cc_if.complete_id_i  = '0;
    endtask

    task automatic check_irq(input string tag, input logic exp_irq, input logic [SRCW-1:0] exp_id);
        check({tag, "_irq"}, 32'(irq_o), 32'(exp_irq));
        check({tag, "_id"}, 32'(irq_id_o), 32'(exp_id));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_irq"}, 32'(irq_o), 32'd0);
        check({tag, "_irq_id"}, 32'(irq_id_o), 32'd0);
        check({tag, "_claim_valid"}, 32'(cc_if.claim_valid_o), 32'd0);
        check({tag, "_claim_id"}, 32'(cc_if.claim_id_o), 32'd0);
        check({tag, "_claimed"}, claimed_o, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [SRCW-1:0] bad_ids [3];
        bad_ids[0] = 6'd0;
        bad_ids[1] = 6'd33;
        bad_ids[2] = 6'd7;

        rst_ni               = 1'b1;
        ip                   = '0;
        ie                   = '0;
        prio                 = '0;
        threshold            = '0;
        cc_if.claim_req_i    = 1'b0;
        cc_if.complete_req_i = 1'b0;
        cc_if.complete_id_i  = '0;

        #1 rst_ni = 1'b0;
        #2 check_all_zero("reset");
        ticks(2);
        rst_ni = 1'b1;

        // Single source above threshold: latency 3, then threshold blocks it.
        ip[4] = 1'b1; ie[4] = 1'b1; prio[4] = 3'd3; threshold = 3'd2;
        ticks(2);
        check("lat_early_irq", 32'(irq_o), 32'd0);
        tick();
        check_irq("single", 1'b1, 6'd5);
        threshold = 3'd3;
        tick();
        check_irq("thresh_eq", 1'b0, 6'd5);

        // Tie between sources 3 and 9 goes to ID 4; raising 9 moves to ID 10.
        ip = '0; ip[3] = 1'b1; ip[9] = 1'b1;
        ie = '1; prio = '0; prio[3] = 3'd5; prio[9] = 3'd5; threshold = 3'd0;
        ticks(3);
        check_irq("tie", 1'b1, 6'd4);
        prio[9] = 3'd6;
        ticks(2);
        check_irq("raise_early", 1'b1, 6'd4);
        tick();
        check_irq("raise", 1'b1, 6'd10);

        // Claim the winner; irq blanked for 3 cycles while the tree settles.
        claim(6'd10);
        check("claim1_claimed", claimed_o, 32'h200);
        check("settle1_irq", 32'(irq_o), 32'd0);
        check("settle1_id", 32'(irq_id_o), 32'd0);
        tick();
        check("settle2_irq", 32'(irq_o), 32'd0);
        tick();
        check("settle3_irq", 32'(irq_o), 32'd0);
        tick();
        check_irq("after_settle", 1'b1, 6'd4);

        // Back-to-back claims: the second returns 0 and changes nothing.
        cc_if.claim_req_i = 1'b1;
        exp_q.push_back(6'd4);
        tick();
        exp_q.push_back(6'd0);
        tick();
        cc_if.claim_req_i = 1'b0;
        check("b2b_claimed", claimed_o, 32'h208);
        tick();
        check("b2b_claimed_hold", claimed_o, 32'h208);

        // Release ID 4, then invalid completions leave claimed_o alone.
        complete(6'd4);
        check("complete4_claimed", claimed_o, 32'h200);
        for (int k = 0; k < 3; k++) begin
            complete(bad_ids[k]);
            check($sformatf("bad_complete_%0d", bad_ids[k]), claimed_o, 32'h200);
        end
        ticks(4);
        check_irq("pre_complete10", 1'b1, 6'd4);

        // Completing 10 with it still pending brings it back after 3 cycles.
        complete(6'd10);
        check("complete10_claimed", claimed_o, 32'h0);
        ticks(2);
        check_irq("complete10_early", 1'b1, 6'd4);
        tick();
        check_irq("complete10", 1'b1, 6'd10);

        // Claim 10 again and reset mid-settle: outputs clear without an edge.
        claim(6'd10);
        check("claim2_claimed", claimed_o, 32'h200);
        tick();
        #1 rst_ni = 1'b0;
        #1 check_all_zero("async_reset");
        ticks(2);
        check_all_zero("reset_hold");
        rst_ni = 1'b1;
        ticks(2);
        check("post_reset_early_irq", 32'(irq_o), 32'd0);
        tick();
        check_irq("post_reset", 1'b1, 6'd10);

        ticks(2);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
